stream_arbiter_wrr_flushable: RTL and testbench

//   N-to-1 valid/ready stream arbiter with selectable round-robin, fixed-priority or weighted

---
 rtl/stream_arbiter_wrr_flushable.sv | 148 ++++++++++++++
 tb/tb_stream_arbiter_wrr_flushable.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arbiter_wrr_flushable.sv
// N-to-1 valid/ready stream arbiter with round-robin, fixed-priority or weighted round-robin
// policy, a registered full-throughput output stage, granted-index output and synchronous flush.
module stream_arbiter_wrr_flushable #(
    parameter int    N_INP        = 4,
    parameter int    DATA_WIDTH   = 64,
    parameter string ARBITER      = "rr",
    parameter int    WEIGHT_WIDTH = 4,
    parameter int    IDX_WIDTH    = (N_INP > 1) ? $clog2(N_INP) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [N_INP*WEIGHT_WIDTH-1:0] weights_i,
    input  logic [N_INP*DATA_WIDTH-1:0]   inp_data_i,
    input  logic [N_INP-1:0]              inp_valid_i,
    output logic [N_INP-1:0]              inp_ready_o,
    output logic [DATA_WIDTH-1:0]         oup_data_o,
    output logic [IDX_WIDTH-1:0]          oup_idx_o,
    output logic                          oup_valid_o,
    input  logic                          oup_ready_i
);

    localparam bit IS_RR   = (ARBITER == "rr");
    localparam bit IS_PRIO = (ARBITER == "prio");
    localparam bit IS_WRR  = (ARBITER == "wrr");
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_INP - 1);

    if (!(IS_RR || IS_PRIO || IS_WRR)) begin : g_bad_arbiter
        $fatal(1, "stream_arbiter_wrr_flushable: unsupported ARBITER value %s", ARBITER);
    end

    // Handshake: a beat moves when valid && ready on the same rising edge. Inputs hold valid and
    // data until ready; ready never depends on the same input's data, and at most one input
    // sees ready per cycle. The output holds data/idx stable while valid && !ready.

    logic                    oup_valid_q;
    logic [DATA_WIDTH-1:0]   oup_data_q;
    logic [IDX_WIDTH-1:0]    oup_idx_q;
    logic [IDX_WIDTH-1:0]    ptr_q;
    logic [WEIGHT_WIDTH-1:0] cnt_q;

    logic                    load_en;
    logic                    any_valid;
    logic                    grant;
    logic [IDX_WIDTH-1:0]    sel;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [WEIGHT_WIDTH-1:0] sel_weight;
    logic [IDX_WIDTH-1:0]    sel_inc;
    logic [WEIGHT_WIDTH-1:0] w_eff;
    logic [WEIGHT_WIDTH-1:0] c_base;
    logic [WEIGHT_WIDTH:0]   c_next;
    logic [IDX_WIDTH-1:0]    ptr_d;
    logic [WEIGHT_WIDTH-1:0] cnt_d;

    assign load_en   = !flush_i && (!oup_valid_q || oup_ready_i);
    assign any_valid = |inp_valid_i;
    assign grant     = load_en && any_valid && !rst_i;

    // Circular search from ptr_q: first the indices at or above the pointer, then the wrap-around.
    // In "prio" mode ptr_q stays 0, so this degenerates to lowest-index-wins.
    always_comb begin : sel_search
        logic found;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_INP; k++) begin
            if (!found && inp_valid_i[k] && (IDX_WIDTH'(k) >= ptr_q)) begin
                found = 1'b1;
                sel   = IDX_WIDTH'(k);
            end
        end
        for (int k = 0; k < N_INP; k++) begin
            if (!found && inp_valid_i[k]) begin
                found = 1'b1;
                sel   = IDX_WIDTH'(k);
            end
        end
    end

    always_comb begin
        sel_data   = '0;
        sel_weight = '0;
        for (int k = 0; k < N_INP; k++) begin
            if (IDX_WIDTH'(k) == sel) begin
                sel_data   = inp_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                sel_weight = weights_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
    end

    always_comb begin
        inp_ready_o = '0;
        for (int k = 0; k < N_INP; k++) begin
            if (grant && (IDX_WIDTH'(k) == sel)) begin
                inp_ready_o[k] = 1'b1;
            end
        end
    end

    // Credits are only carried while the pointer input keeps winning; any other winner
    // starts from zero, forfeiting what the pointer input had left.
    always_comb begin
        sel_inc = (sel == LAST_IDX) ? '0 : sel + 1'b1;
        w_eff   = (sel_weight == '0) ? WEIGHT_WIDTH'(1) : sel_weight;
        c_base  = (sel == ptr_q) ? cnt_q : '0;
        c_next  = {1'b0, c_base} + 1'b1;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (IS_RR) begin
            ptr_d = sel_inc;
            cnt_d = '0;
        end else if (IS_WRR) begin
            if (c_next >= {1'b0, w_eff}) begin
                ptr_d = sel_inc;
                cnt_d = '0;
            end else begin
                ptr_d = sel;
                cnt_d = c_next[WEIGHT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            oup_valid_q <= 1'b0;
            oup_data_q  <= '0;
            oup_idx_q   <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else if (flush_i) begin
            oup_valid_q <= 1'b0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else if (grant) begin
            oup_valid_q <= 1'b1;
            oup_data_q  <= sel_data;
            oup_idx_q   <= sel;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end else if (oup_ready_i) begin
            oup_valid_q <= 1'b0;
        end
    end

    assign oup_valid_o = oup_valid_q;
    assign oup_data_o  = oup_data_q;
    assign oup_idx_o   = oup_idx_q;

endmodule

// File: tb/tb_stream_arbiter_wrr_flushable.sv
// Bench: four arbiter instances (rr, wrr, prio with 4 inputs; rr with 3 inputs) share one
// stimulus stream and are checked cycle by cycle against a behavioural model.
module tb_stream_arbiter_wrr_flushable;

    localparam int DW = 16;
    localparam int WW = 4;
    localparam int NI = 4;
    localparam int NM = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             flush;
    logic [NI*WW-1:0] weights;
    logic [NI*DW-1:0] inp_data;
    logic [NI-1:0]    inp_valid;
    logic             oup_ready;

    logic [NI-1:0] ready_rr, ready_wrr, ready_prio;
    logic [2:0]    ready_rr3;
    logic [DW-1:0] data_rr, data_wrr, data_prio, data_rr3;
    logic [1:0]    idx_rr, idx_wrr, idx_prio, idx_rr3;
    logic          valid_rr, valid_wrr, valid_prio, valid_rr3;

    stream_arbiter_wrr_flushable #(.N_INP(4), .DATA_WIDTH(DW), .ARBITER("rr"), .WEIGHT_WIDTH(WW)) u_rr (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .weights_i(weights), .inp_data_i(inp_data),
        .inp_valid_i(inp_valid), .inp_ready_o(ready_rr), .oup_data_o(data_rr), .oup_idx_o(idx_rr),
        .oup_valid_o(valid_rr), .oup_ready_i(oup_ready));

    stream_arbiter_wrr_flushable #(.N_INP(4), .DATA_WIDTH(DW), .ARBITER("wrr"), .WEIGHT_WIDTH(WW)) u_wrr (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .weights_i(weights), .inp_data_i(inp_data),
        .inp_valid_i(inp_valid), .inp_ready_o(ready_wrr), .oup_data_o(data_wrr), .oup_idx_o(idx_wrr),
        .oup_valid_o(valid_wrr), .oup_ready_i(oup_ready));

    stream_arbiter_wrr_flushable #(.N_INP(4), .DATA_WIDTH(DW), .ARBITER("prio"), .WEIGHT_WIDTH(WW)) u_prio (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .weights_i(weights), .inp_data_i(inp_data),
        .inp_valid_i(inp_valid), .inp_ready_o(ready_prio), .oup_data_o(data_prio), .oup_idx_o(idx_prio),
        .oup_valid_o(valid_prio), .oup_ready_i(oup_ready));

    stream_arbiter_wrr_flushable #(.N_INP(3), .DATA_WIDTH(DW), .ARBITER("rr"), .WEIGHT_WIDTH(WW)) u_rr3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .weights_i(weights[3*WW-1:0]),
        .inp_data_i(inp_data[3*DW-1:0]), .inp_valid_i(inp_valid[2:0]), .inp_ready_o(ready_rr3),
        .oup_data_o(data_rr3), .oup_idx_o(idx_rr3), .oup_valid_o(valid_rr3), .oup_ready_i(oup_ready));

    // ---------------- behavioural model ----------------
    // policy: 0 = rr, 1 = wrr, 2 = prio
    int            pol[NM] = '{0, 1, 2, 0};
    int            nin[NM] = '{4, 4, 4, 3};
    int            m_ptr[NM];
    int            m_used[NM];
    int            m_idx[NM];
    bit            m_val[NM];
    logic [DW-1:0] m_data[NM];

    int vectors     = 0;
    int miscompares = 0;
    logic [1:0] exp_q[$];

    function automatic int pick(int j);
        int start;
        start = (pol[j] == 2) ? 0 : m_ptr[j];
        for (int o = 0; o < nin[j]; o++) begin
            int k;
            k = (start + o) % nin[j];
            if (inp_valid[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [63:0] exp_ready(int j);
        int g;
        g = pick(j);
        if (!rst && !flush && (!m_val[j] || oup_ready) && g >= 0) return 64'd1 << g;
        return 64'd0;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < NM; j++) begin
            m_ptr[j] = 0; m_used[j] = 0; m_idx[j] = 0; m_val[j] = 1'b0; m_data[j] = '0;
        end
    endtask

    task automatic model_step(int j);
        int g, w, u;
        if (flush) begin
            m_val[j] = 1'b0; m_ptr[j] = 0; m_used[j] = 0;
            return;
        end
        g = pick(j);
        if ((!m_val[j] || oup_ready) && g >= 0) begin
            m_val[j]  = 1'b1;
            m_data[j] = inp_data[g*DW +: DW];
            m_idx[j]  = g;
            if (pol[j] == 0) begin
                m_ptr[j] = (g + 1) % nin[j]; m_used[j] = 0;
            end else if (pol[j] == 1) begin
                // an input keeps the turn until it has used its weight in grants
                w = int'(weights[g*WW +: WW]);
                if (w == 0) w = 1;
                u = (g == m_ptr[j]) ? m_used[j] + 1 : 1;
                if (u >= w) begin
                    m_ptr[j] = (g + 1) % nin[j]; m_used[j] = 0;
                end else begin
                    m_ptr[j] = g; m_used[j] = u;
                end
            end
        end else if (oup_ready) begin
            m_val[j] = 1'b0;
        end
    endtask

    // ---------------- DUT observation ----------------
    function automatic logic [63:0] dut_ready(int j);
        case (j)
            0: return 64'(ready_rr);
            1: return 64'(ready_wrr);
            2: return 64'(ready_prio);
            default: return 64'(ready_rr3);
        endcase
    endfunction

    function automatic logic [63:0] dut_valid(int j);
        case (j)
            0: return 64'(valid_rr);
            1: return 64'(valid_wrr);
            2: return 64'(valid_prio);
            default: return 64'(valid_rr3);
        endcase
    endfunction

    function automatic logic [63:0] dut_data(int j);
        case (j)
            0: return 64'(data_rr);
            1: return 64'(data_wrr);
            2: return 64'(data_prio);
            default: return 64'(data_rr3);
        endcase
    endfunction

    function automatic logic [63:0] dut_idx(int j);
        case (j)
            0: return 64'(idx_rr);
            1: return 64'(idx_wrr);
            2: return 64'(idx_prio);
            default: return 64'(idx_rr3);
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ready();
        for (int j = 0; j < NM; j++)
            chk($sformatf("inst%0d_ready", j), dut_ready(j), exp_ready(j));
    endtask

    task automatic check_outputs();
        for (int j = 0; j < NM; j++) begin
            chk($sformatf("inst%0d_valid", j), dut_valid(j), 64'(m_val[j]));
            chk($sformatf("inst%0d_data", j), dut_data(j), 64'(m_data[j]));
            chk($sformatf("inst%0d_idx", j), dut_idx(j), 64'(m_idx[j]));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        #1;
        check_ready();
        for (int j = 0; j < NM; j++) model_step(j);
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic drive(logic [NI-1:0] v);
        inp_valid = v;
        inp_data  = {$urandom(), $urandom()};
    endtask

    task automatic flush_cycle();
        flush = 1'b1;
        drive(4'hf);
        cycle();
        flush = 1'b0;
    endtask

    task automatic dir_run(int j, int ncyc, logic [NI-1:0] v);
        logic [1:0] e;
        for (int i = 0; i < ncyc; i++) begin
            drive(v);
            cycle();
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("dir%0d_idx_%0d", j, i), dut_idx(j), 64'(e));
                chk($sformatf("dir%0d_valid_%0d", j, i), dut_valid(j), 64'd1);
            end
        end
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int j = 0; j < NM; j++) begin
            chk($sformatf("areset%0d_valid", j), dut_valid(j), 64'd0);
            chk($sformatf("areset%0d_data", j), dut_data(j), 64'd0);
            chk($sformatf("areset%0d_idx", j), dut_idx(j), 64'd0);
        end
        check_ready();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        flush     = 1'b0;
        weights   = {4'd2, 4'd0, 4'd3, 4'd1};
        oup_ready = 1'b1;
        drive(4'hf);
        model_reset();

        @(posedge clk);
        #1;
        check_ready();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // round-robin order, 4 inputs then 3 inputs (wrap 2 -> 0)
        flush_cycle();
        foreach (exp_q[i]) exp_q.delete(i);
        for (int i = 0; i < 8; i++) exp_q.push_back(2'(i % 4));
        dir_run(0, 8, 4'hf);
        flush_cycle();
        for (int i = 0; i < 6; i++) exp_q.push_back(2'(i % 3));
        dir_run(3, 6, 4'hf);

        // weighted round-robin, weights {1,3,0,2}
        flush_cycle();
        exp_q = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1};
        dir_run(1, 9, 4'hf);

        // fixed priority: 1 beats 3; once 1 drops, 3 wins
        flush_cycle();
        exp_q = '{2'd1, 2'd1, 2'd1};
        dir_run(2, 3, 4'b1010);
        exp_q = '{2'd3, 2'd3};
        dir_run(2, 2, 4'b1000);

        // backpressure: beat held for 5 cycles, then accepted with the next one loaded
        drive(4'hf);
        cycle();
        oup_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(4'hf);
            cycle();
            chk($sformatf("bp_ready_%0d", i), dut_ready(0), 64'd0);
        end
        oup_ready = 1'b1;
        drive(4'hf);
        cycle();
        chk("bp_release_valid", dut_valid(0), 64'd1);

        // flush in the middle of a wrr run restores 4 full credits for input 0
        weights = {4'd4, 4'd4, 4'd4, 4'd4};
        flush_cycle();
        exp_q = '{2'd0, 2'd0};
        dir_run(1, 2, 4'hf);
        flush_cycle();
        chk("flush_wrr_valid", dut_valid(1), 64'd0);
        exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
        dir_run(1, 5, 4'hf);

        // randomized traffic with flushes, weight changes and one async reset
        for (int i = 0; i < 400; i++) begin
            if (i % 37 == 0) weights = 16'($urandom());
            drive(4'($urandom_range(0, 15)));
            oup_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            if (i == 200) begin
                inp_valid = 4'hf;
                flush     = 1'b0;
                async_reset();
            end else begin
                cycle();
            end
        end
        flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
